// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access pipeline stage between EXE and writeback. Loads and stores go
// to the data cache through a valid/ready request channel and a valid-only
// response channel. Only one access is in flight at a time. While an access is
// in flight, upstream is held by STALL_OUT. Non-memory instructions pass
// through to the writeback registers with one cycle of latency.
//
// Ports
//   CLK, RESET            clock and asynchronous active-low reset
//   Instr1_IN/_PC_IN      instruction word and PC from EXE (debug only)
//   ALU_result1_IN        ALU result, or effective address for memory ops
//   WriteRegister1_IN     destination register
//   RegWrite1_IN          destination write enable
//   MemWriteData1_IN      store data
//   ALU_Control1_IN       selects the access width and signedness
//   MemRead1_IN/Write1_IN access type; when both are set the access is a load
//   STALL_OUT             combinational hold request to upstream
//   dreq_*                cache request (word-aligned address, big-endian lanes)
//   dresp_*               cache load response
//   *_OUT                 registered writeback outputs
//   *_MEMEXE              MEM->EXE bypass; mirrors the writeback outputs
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter logic [5:0] ALU_LB  = 6'b101000,
  parameter logic [5:0] ALU_LBU = 6'b101001,
  parameter logic [5:0] ALU_LH  = 6'b101010,
  parameter logic [5:0] ALU_LHU = 6'b101011,
  parameter logic [5:0] ALU_SB  = 6'b101100,
  parameter logic [5:0] ALU_SH  = 6'b101101
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic        RegWrite1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  output logic        STALL_OUT,
  output logic        dreq_valid,
  input  logic        dreq_ready,
  output logic        dreq_write,
  output logic [31:0] dreq_addr,
  output logic [31:0] dreq_wdata,
  output logic [3:0]  dreq_byteen,
  input  logic        dresp_valid,
  input  logic [31:0] dresp_rdata,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic        RegWrite1_OUT,
  output logic [4:0]  BypassReg1_MEMEXE,
  output logic [31:0] BypassData1_MEMEXE,
  output logic        BypassValid1_MEMEXE
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        dreq_valid_q, dreq_valid_d;
  logic        dreq_write_q, dreq_write_d;
  logic [31:0] dreq_addr_q, dreq_addr_d;
  logic [31:0] dreq_wdata_q, dreq_wdata_d;
  logic [3:0]  dreq_byteen_q, dreq_byteen_d;
  logic [5:0]  req_ctrl_q, req_ctrl_d;
  logic [1:0]  req_off_q, req_off_d;
  logic [31:0] load_data_q, load_data_d;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        regwrite_q, regwrite_d;

  logic        mem_op;
  logic        is_load;
  logic        is_store;
  logic        stall;
  logic [1:0]  in_off;
  logic [3:0]  in_byteen;
  logic [31:0] in_wdata;

  // Picks the addressed big-endian lane out of the returned word and extends
  // it according to the load type captured when the request was issued.
  function automatic logic [31:0] format_load(input logic [5:0]  ctrl,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[31:24];
      2'd1:    b = rdata[23:16];
      2'd2:    b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = off[1] ? rdata[15:0] : rdata[31:16];
    if (ctrl == ALU_LB)       format_load = {{24{b[7]}}, b};
    else if (ctrl == ALU_LBU) format_load = {24'd0, b};
    else if (ctrl == ALU_LH)  format_load = {{16{h[15]}}, h};
    else if (ctrl == ALU_LHU) format_load = {16'd0, h};
    else                      format_load = rdata;
  endfunction

  // Decode the incoming instruction and build the store lane enables and
  // replicated write data; loads always request the full word.
  always_comb begin
    mem_op    = MemRead1_IN | MemWrite1_IN;
    is_load   = MemRead1_IN;
    is_store  = MemWrite1_IN & ~MemRead1_IN;
    in_off    = ALU_result1_IN[1:0];
    in_byteen = 4'b1111;
    in_wdata  = 32'd0;
    if (is_store) begin
      if (ALU_Control1_IN == ALU_SB) begin
        in_byteen = 4'b1000 >> in_off;
        in_wdata  = {4{MemWriteData1_IN[7:0]}};
      end else if (ALU_Control1_IN == ALU_SH) begin
        in_byteen = in_off[1] ? 4'b0011 : 4'b1100;
        in_wdata  = {2{MemWriteData1_IN[15:0]}};
      end else begin
        in_wdata  = MemWriteData1_IN;
      end
    end
  end

  // Upstream is released in DONE so the finished instruction retires there.
  assign stall     = mem_op && (state_q != DONE);
  assign STALL_OUT = stall;

  // Access sequencer. The request payload is captured once in IDLE and held
  // untouched until the cache accepts it.
  always_comb begin
    state_d       = state_q;
    dreq_valid_d  = dreq_valid_q;
    dreq_write_d  = dreq_write_q;
    dreq_addr_d   = dreq_addr_q;
    dreq_wdata_d  = dreq_wdata_q;
    dreq_byteen_d = dreq_byteen_q;
    req_ctrl_d    = req_ctrl_q;
    req_off_d     = req_off_q;
    load_data_d   = load_data_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d       = REQ;
          dreq_valid_d  = 1'b1;
          dreq_write_d  = ~is_load;
          dreq_addr_d   = {ALU_result1_IN[31:2], 2'b00};
          dreq_wdata_d  = in_wdata;
          dreq_byteen_d = in_byteen;
          req_ctrl_d    = ALU_Control1_IN;
          req_off_d     = in_off;
        end
      end
      REQ: begin
        if (dreq_ready) begin
          dreq_valid_d = 1'b0;
          state_d      = dreq_write_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dresp_valid) begin
          load_data_d = format_load(req_ctrl_q, req_off_q, dresp_rdata);
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // Writeback register inputs: a bubble while stalled, otherwise the
  // instruction itself. Stores never write the register file.
  always_comb begin
    instr_d    = 32'd0;
    pc_d       = 32'd0;
    wreg_d     = 5'd0;
    wdata_d    = 32'd0;
    regwrite_d = 1'b0;
    if (!stall) begin
      instr_d    = Instr1_IN;
      pc_d       = Instr1_PC_IN;
      wreg_d     = WriteRegister1_IN;
      wdata_d    = is_load ? load_data_q : ALU_result1_IN;
      regwrite_d = RegWrite1_IN & ~is_store;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      dreq_valid_q  <= 1'b0;
      dreq_write_q  <= 1'b0;
      dreq_addr_q   <= 32'd0;
      dreq_wdata_q  <= 32'd0;
      dreq_byteen_q <= 4'd0;
      req_ctrl_q    <= 6'd0;
      req_off_q     <= 2'd0;
      load_data_q   <= 32'd0;
      instr_q       <= 32'd0;
      pc_q          <= 32'd0;
      wreg_q        <= 5'd0;
      wdata_q       <= 32'd0;
      regwrite_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dreq_valid_q  <= dreq_valid_d;
      dreq_write_q  <= dreq_write_d;
      dreq_addr_q   <= dreq_addr_d;
      dreq_wdata_q  <= dreq_wdata_d;
      dreq_byteen_q <= dreq_byteen_d;
      req_ctrl_q    <= req_ctrl_d;
      req_off_q     <= req_off_d;
      load_data_q   <= load_data_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      wreg_q        <= wreg_d;
      wdata_q       <= wdata_d;
      regwrite_q    <= regwrite_d;
    end
  end

  assign dreq_valid          = dreq_valid_q;
  assign dreq_write          = dreq_write_q;
  assign dreq_addr           = dreq_addr_q;
  assign dreq_wdata          = dreq_wdata_q;
  assign dreq_byteen         = dreq_byteen_q;
  assign Instr1_OUT          = instr_q;
  assign Instr1_PC_OUT       = pc_q;
  assign WriteRegister1_OUT  = wreg_q;
  assign WriteData1_OUT      = wdata_q;
  assign RegWrite1_OUT       = regwrite_q;
  assign BypassReg1_MEMEXE   = wreg_q;
  assign BypassData1_MEMEXE  = wdata_q;
  assign BypassValid1_MEMEXE = regwrite_q;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// Bench for mem_stage: a driver issues one instruction at a time, a cache
// responder serves requests with configurable delays, and two monitors pop
// expected writeback results and cache requests from scoreboard queues.
module tb_mem_stage;

  localparam logic [5:0] C_LB  = 6'b101000;
  localparam logic [5:0] C_LBU = 6'b101001;
  localparam logic [5:0] C_LH  = 6'b101010;
  localparam logic [5:0] C_LHU = 6'b101011;
  localparam logic [5:0] C_SB  = 6'b101100;
  localparam logic [5:0] C_SH  = 6'b101101;
  localparam logic [5:0] C_W   = 6'b010000;
  localparam logic [5:0] C_ADD = 6'b000001;

  logic        CLK, RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        STALL_OUT, dreq_valid, dreq_ready, dreq_write;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [3:0]  dreq_byteen;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, BypassData1_MEMEXE;
  logic [4:0]  WriteRegister1_OUT, BypassReg1_MEMEXE;
  logic        RegWrite1_OUT, BypassValid1_MEMEXE;

  mem_stage dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
    .RegWrite1_IN(RegWrite1_IN), .MemWriteData1_IN(MemWriteData1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .MemRead1_IN(MemRead1_IN),
    .MemWrite1_IN(MemWrite1_IN), .STALL_OUT(STALL_OUT),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_write(dreq_write),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_byteen(dreq_byteen),
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .WriteData1_OUT(WriteData1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT), .BypassReg1_MEMEXE(BypassReg1_MEMEXE),
    .BypassData1_MEMEXE(BypassData1_MEMEXE), .BypassValid1_MEMEXE(BypassValid1_MEMEXE)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        rw;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } req_t;

  exp_t        expQ[$];
  req_t        reqQ[$];
  logic [31:0] memModel [0:255];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rspReadyDly = 0;
  int          rspDataDly = 0;
  bit          rspStray = 0;

  // 100 MHz clock and a free-running cycle count used for retire timing.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Hard stop in case the design wedges the handshake completely.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives an all-zero instruction, which the stage turns into a bubble.
  task automatic driveBubble();
    Instr1_IN = 0; Instr1_PC_IN = 0; ALU_result1_IN = 0; MemWriteData1_IN = 0;
    WriteRegister1_IN = 0; RegWrite1_IN = 0; ALU_Control1_IN = 0;
    MemRead1_IN = 0; MemWrite1_IN = 0;
  endtask

  // Presents one instruction, works out what writeback and the cache should
  // see from the memory model, then holds it until STALL_OUT drops and it
  // retires. Called and returns #1 after a rising edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] alu, input logic [31:0] sdata,
                               input logic [4:0] wreg, input logic rw,
                               input logic [5:0] ctrl, input logic mr, input logic mw,
                               input int rd, input int dd, input bit stray);
    exp_t        e;
    req_t        r;
    int          expStall, stalls, sh, idx;
    logic [31:0] word, res;
    logic [1:0]  off;
    bit          released;
    off = alu[1:0];
    idx = int'(alu[9:2]);
    sh  = 8 * (3 - int'(off));
    word = memModel[idx];
    e.instr = instr; e.pc = pc; e.wreg = wreg; e.rw = rw; e.wdata = alu;
    r.write = 1'b0; r.addr = alu & ~32'h3; r.wdata = 32'd0; r.byteen = 4'hF;
    expStall = 0;
    if (mr) begin
      if (ctrl == C_LB || ctrl == C_LBU) begin
        res = (word >> sh) & 32'hFF;
        if (ctrl == C_LB && res >= 128) res = res - 256;
      end else if (ctrl == C_LH || ctrl == C_LHU) begin
        res = (word >> (off[1] ? 0 : 16)) & 32'hFFFF;
        if (ctrl == C_LH && res >= 32768) res = res - 65536;
      end else begin
        res = word;
      end
      e.wdata  = res;
      expStall = 3 + rd + dd;
    end else if (mw) begin
      e.rw     = 1'b0;
      r.write  = 1'b1;
      expStall = 2 + rd;
      if (ctrl == C_SB) begin
        r.byteen = 4'(1 << (3 - int'(off)));
        r.wdata  = {24'd0, sdata[7:0]} * 32'h01010101;
        word     = (word & ~(32'hFF << sh)) | ({24'd0, sdata[7:0]} << sh);
      end else if (ctrl == C_SH) begin
        r.byteen = 4'(3 << (off[1] ? 0 : 2));
        r.wdata  = {16'd0, sdata[15:0]} * 32'h00010001;
        word     = (word & ~(32'hFFFF << (off[1] ? 0 : 16))) |
                   ({16'd0, sdata[15:0]} << (off[1] ? 0 : 16));
      end else begin
        r.wdata  = sdata;
        word     = sdata;
      end
      memModel[idx] = word;
    end
    e.cyc = cyc + expStall + 1;
    expQ.push_back(e);
    if (mr || mw) reqQ.push_back(r);
    rspReadyDly = rd; rspDataDly = dd; rspStray = stray;
    Instr1_IN = instr; Instr1_PC_IN = pc; ALU_result1_IN = alu; MemWriteData1_IN = sdata;
    WriteRegister1_IN = wreg; RegWrite1_IN = rw; ALU_Control1_IN = ctrl;
    MemRead1_IN = mr; MemWrite1_IN = mw;
    stalls = 0;
    released = 0;
    for (int i = 0; i < 60 && !released; i++) begin
      @(negedge CLK);
      if (STALL_OUT) stalls++;
      else released = 1;
    end
    checkOutput("stall_cycles", stalls, expStall);
    @(posedge CLK); #1;
  endtask

  // Pulls reset while a load sits in WAIT with its response still pending.
  task automatic resetMidAccess();
    req_t r;
    r.write = 1'b0; r.addr = 32'h0000_0084; r.wdata = 0; r.byteen = 4'hF;
    reqQ.push_back(r);
    rspReadyDly = 0; rspDataDly = 6; rspStray = 0;
    Instr1_IN = 32'hDEAD0001; Instr1_PC_IN = 32'h400; ALU_result1_IN = 32'h0000_0086;
    MemWriteData1_IN = 0; WriteRegister1_IN = 5'd9; RegWrite1_IN = 1;
    ALU_Control1_IN = C_W; MemRead1_IN = 1; MemWrite1_IN = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK); #2;
    RESET = 1'b0;
    driveBubble();
    #1;
    checkOutput("rst_dreq_valid", dreq_valid, 0);
    checkOutput("rst_dreq_write", dreq_write, 0);
    checkOutput("rst_dreq_addr", dreq_addr, 0);
    checkOutput("rst_dreq_wdata", dreq_wdata, 0);
    checkOutput("rst_dreq_byteen", dreq_byteen, 0);
    checkOutput("rst_stall", STALL_OUT, 0);
    checkOutput("rst_wb", Instr1_OUT | Instr1_PC_OUT | WriteData1_OUT | BypassData1_MEMEXE, 0);
    checkOutput("rst_wb_ctl", {RegWrite1_OUT, BypassValid1_MEMEXE, WriteRegister1_OUT, BypassReg1_MEMEXE}, 0);
    reqQ.delete();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
  endtask

  // Cache model: accepts after rspReadyDly cycles, optionally raising a stray
  // response while the request waits, and returns load data rspDataDly
  // cycles after acceptance. Signals change #1 after the rising edge.
  initial begin : responder
    logic        wr;
    logic [31:0] a;
    dreq_ready = 0; dresp_valid = 0; dresp_rdata = 0;
    forever begin
      @(posedge CLK); #1;
      if (RESET && dreq_valid) begin
        for (int i = 0; i < rspReadyDly; i++) begin
          if (rspStray) begin dresp_valid = 1; dresp_rdata = $urandom; end
          @(posedge CLK); #1;
          dresp_valid = 0;
        end
        dreq_ready = 1; wr = dreq_write; a = dreq_addr;
        @(posedge CLK); #1;
        dreq_ready = 0;
        if (!wr) begin
          for (int i = 0; i < rspDataDly; i++) begin @(posedge CLK); #1; end
          dresp_valid = 1; dresp_rdata = memModel[a[9:2]];
          @(posedge CLK); #1;
          dresp_valid = 0; dresp_rdata = $urandom;
        end
      end
    end
  end

  // Writeback monitor: a nonzero instruction on the outputs is a retirement
  // and is matched against the scoreboard; anything else must be a bubble.
  initial begin : wbMonitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (Instr1_OUT != 0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_retire", Instr1_OUT, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("wb_instr", Instr1_OUT, e.instr);
          checkOutput("wb_pc", Instr1_PC_OUT, e.pc);
          checkOutput("wb_reg", WriteRegister1_OUT, e.wreg);
          checkOutput("wb_data", WriteData1_OUT, e.wdata);
          checkOutput("wb_regwrite", RegWrite1_OUT, e.rw);
          checkOutput("byp_reg", BypassReg1_MEMEXE, e.wreg);
          checkOutput("byp_data", BypassData1_MEMEXE, e.wdata);
          checkOutput("byp_valid", BypassValid1_MEMEXE, e.rw);
          checkOutput("retire_cycle", cyc, e.cyc);
        end
      end else begin
        checkOutput("bubble", Instr1_PC_OUT | WriteData1_OUT | BypassData1_MEMEXE |
                    {22'd0, WriteRegister1_OUT, BypassReg1_MEMEXE} |
                    {30'd0, RegWrite1_OUT, BypassValid1_MEMEXE}, 0);
      end
    end
  end

  // Request monitor: every cycle dreq_valid is high the payload must equal
  // the front expected request; it is retired when the cache accepts it.
  initial begin : reqMonitor
    forever begin
      @(negedge CLK);
      if (RESET && dreq_valid) begin
        if (reqQ.size() == 0) begin
          checkOutput("unexpected_req", dreq_valid, 0);
        end else begin
          checkOutput("req_write", dreq_write, reqQ[0].write);
          checkOutput("req_addr", dreq_addr, reqQ[0].addr);
          checkOutput("req_wdata", dreq_wdata, reqQ[0].wdata);
          checkOutput("req_byteen", dreq_byteen, reqQ[0].byteen);
          if (dreq_ready) void'(reqQ.pop_front());
        end
      end
    end
  end

  // Main sequence: reset, directed cases, then randomized traffic.
  initial begin : driver
    int kind;
    logic [5:0] c;
    for (int i = 0; i < 256; i++) memModel[i] = $urandom;
    driveBubble();
    RESET = 1'b0;
    #2;
    checkOutput("reset_dreq", {dreq_valid, dreq_write, dreq_byteen}, 0);
    checkOutput("reset_addr_wdata", dreq_addr | dreq_wdata, 0);
    checkOutput("reset_wb", Instr1_OUT | Instr1_PC_OUT | WriteData1_OUT, 0);
    checkOutput("reset_stall", STALL_OUT, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;

    applyStimulus(32'h0000_1001, 32'h100, 32'h1234, 0, 5'd5, 1, C_ADD, 0, 0, 0, 0, 0);
    memModel[8'h40] = 32'h0000_00F0;
    applyStimulus(32'h0000_1002, 32'h104, 32'h103, 0, 5'd6, 1, C_LB, 1, 0, 0, 0, 0);
    applyStimulus(32'h0000_1003, 32'h108, 32'h103, 0, 5'd7, 1, C_LBU, 1, 0, 0, 0, 0);
    applyStimulus(32'h0000_1004, 32'h10C, 32'h202, 32'hABCD1234, 5'd8, 1, C_SH, 0, 1, 0, 0, 0);
    applyStimulus(32'h0000_1005, 32'h110, 32'h202, 0, 5'd10, 1, C_W, 1, 0, 4, 0, 1);
    resetMidAccess();
    applyStimulus(32'h0000_1006, 32'h114, 32'h84, 0, 5'd11, 1, C_LH, 1, 0, 0, 0, 0);
    applyStimulus(32'h0000_1007, 32'h118, 32'h1F0, 0, 5'd12, 1, C_W, 1, 0, 1, 2, 0);
    applyStimulus(32'h0000_1008, 32'h11C, 32'h5555, 0, 5'd12, 1, C_ADD, 0, 0, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 5);
      if (kind == 5) begin
        driveBubble();
        @(posedge CLK); #1;
      end else if (kind <= 1) begin
        applyStimulus($urandom | 32'h1, $urandom, $urandom, $urandom, 5'($urandom),
                      1'($urandom), C_ADD, 0, 0, 0, 0, 0);
      end else if (kind <= 3) begin
        case ($urandom_range(0, 4))
          0: c = C_LB; 1: c = C_LBU; 2: c = C_LH; 3: c = C_LHU; default: c = C_W;
        endcase
        applyStimulus($urandom | 32'h1, $urandom, $urandom, $urandom, 5'($urandom),
                      1'($urandom), c, 1, 0, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom));
      end else begin
        case ($urandom_range(0, 2))
          0: c = C_SB; 1: c = C_SH; default: c = C_W;
        endcase
        applyStimulus($urandom | 32'h1, $urandom, $urandom, $urandom, 5'($urandom),
                      1'($urandom), c, 0, 1, $urandom_range(0, 3), 0, 1'($urandom));
      end
    end

    driveBubble();
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("scoreboard_drained", expQ.size(), 0);
    checkOutput("requests_drained", reqQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
